// File: rtl/bats_pitch_pkg.sv
// Shared constants, command/unit types and the sequenced-unit builder for the BATS PITCH encoder.
// The optional BATS_ENC_AUTO_TIME_EN feature lives in bats_pitch_encoder and only uses what is here.
package bats_pitch_pkg;

  localparam logic [7:0] MSG_TIME     = 8'h20;
  localparam logic [7:0] MSG_ADD_LONG = 8'h21;
  localparam logic [7:0] MSG_EXECUTED = 8'h23;
  localparam logic [7:0] MSG_DELETE   = 8'h29;

  localparam logic [5:0] HDR_LEN      = 6'd8;
  localparam logic [5:0] LEN_TIME     = 6'd6;
  localparam logic [5:0] LEN_DELETE   = 6'd14;
  localparam logic [5:0] LEN_EXECUTED = 6'd26;
  localparam logic [5:0] LEN_ADD_LONG = 6'd34;

  typedef enum logic [1:0] {ST_IDLE, ST_TIME_SEND, ST_SEND} state_e;

  typedef struct packed {
    logic [7:0]  typ;
    logic [31:0] seconds;
    logic [31:0] nanoseconds;
    logic [63:0] order_id;
    logic [7:0]  side;
    logic [31:0] quantity;
    logic [47:0] symbol;
    logic [63:0] price;
    logic [63:0] exec_id;
  } cmd_t;

  // data holds the unit left-justified: first wire byte in [383:376], tail zero-filled.
  typedef struct packed {
    logic [383:0] data;
    logic [2:0]   n_words;
    logic [7:0]   last_be;
  } unit_t;

  function automatic logic [15:0] le16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic logic [31:0] le32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] le64(input logic [63:0] x);
    return {le32(x[31:0]), le32(x[63:32])};
  endfunction

  function automatic logic [5:0] msg_len(input logic [7:0] typ);
    case (typ)
      MSG_TIME:     return LEN_TIME;
      MSG_DELETE:   return LEN_DELETE;
      MSG_EXECUTED: return LEN_EXECUTED;
      MSG_ADD_LONG: return LEN_ADD_LONG;
      default:      return 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] last_be(input logic [5:0] len);
    if (len[2:0] == 3'd0) return 8'hFF;
    return ~(8'hFF >> len[2:0]);
  endfunction

  function automatic unit_t build_unit(input cmd_t c, input logic [7:0] unit_id,
                                       input logic [31:0] seq);
    unit_t       u;
    logic [5:0]  ulen;
    logic [63:0] hdr;
    ulen = HDR_LEN + msg_len(c.typ);
    hdr  = {le16({10'd0, ulen}), 8'd1, unit_id, le32(seq)};
    case (c.typ)
      MSG_TIME:
        u.data = {hdr, {2'b0, LEN_TIME}, MSG_TIME, le32(c.seconds), 272'd0};
      MSG_DELETE:
        u.data = {hdr, {2'b0, LEN_DELETE}, MSG_DELETE, le32(c.nanoseconds),
                  le64(c.order_id), 208'd0};
      MSG_EXECUTED:
        u.data = {hdr, {2'b0, LEN_EXECUTED}, MSG_EXECUTED, le32(c.nanoseconds),
                  le64(c.order_id), le32(c.quantity), le64(c.exec_id), 112'd0};
      MSG_ADD_LONG:
        u.data = {hdr, {2'b0, LEN_ADD_LONG}, MSG_ADD_LONG, le32(c.nanoseconds),
                  le64(c.order_id), c.side, le32(c.quantity), c.symbol,
                  le64(c.price), 8'h00, 48'd0};
      default:
        u.data = '0;
    endcase
    u.n_words = 3'((ulen + 6'd7) >> 3);
    u.last_be = last_be(ulen);
    return u;
  endfunction

endpackage

// File: rtl/bats_pitch_encoder_serializer.sv
// bats_word_serializer: holds one sequenced unit and streams it as 64-bit words with valid/ready.
// A load takes priority and may land in the same cycle the previous unit's last word is accepted.
module bats_word_serializer
  import bats_pitch_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  unit_t       unit_i,
  input  logic        out_ready_i,
  output logic [63:0] out_bytes_o,
  output logic [7:0]  out_be_o,
  output logic        out_valid_o,
  output logic        last_accept_o
);

  logic [63:0] words_q [6];
  logic [2:0]  idx_q;
  logic [2:0]  n_q;
  logic [7:0]  be_q;
  logic        valid_q;
  logic        is_last;

  assign is_last       = (idx_q == n_q - 3'd1);
  assign last_accept_o = valid_q & out_ready_i & is_last;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      be_q    <= '0;
      for (int k = 0; k < 6; k++) words_q[k] <= '0;
    end else if (load_i) begin
      for (int k = 0; k < 6; k++) words_q[k] <= unit_i.data[383-64*k -: 64];
      idx_q   <= '0;
      n_q     <= unit_i.n_words;
      be_q    <= unit_i.last_be;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready_i) begin
      if (is_last) valid_q <= 1'b0;
      else         idx_q   <= idx_q + 3'd1;
    end
  end

  assign out_valid_o = valid_q;
  assign out_bytes_o = valid_q ? words_q[idx_q] : 64'd0;
  assign out_be_o    = !valid_q ? 8'h00 : (is_last ? be_q : 8'hFF);

endmodule

// File: rtl/bats_pitch_encoder.sv
// BATS PITCH transmit encoder: one command -> one sequenced unit streamed as 64-bit words.
// Define BATS_ENC_AUTO_TIME_EN to prepend a Time unit whenever a command's seconds change.
//   state        | meaning
//   ST_IDLE      | cmd_ready high, waiting for a command
//   ST_TIME_SEND | streaming an inserted Time unit; command unit queued behind it
//   ST_SEND      | streaming the command's own unit
module bats_pitch_encoder
  import bats_pitch_pkg::*;
#(
  parameter logic [7:0]  UNIT_ID  = 8'd1,
  parameter logic [31:0] SEQ_INIT = 32'd1
) (
  input  logic        Clk40,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_type,
  input  logic [31:0] cmd_seconds,
  input  logic [31:0] cmd_nanoseconds,
  input  logic [63:0] cmd_order_id,
  input  logic [7:0]  cmd_side,
  input  logic [31:0] cmd_quantity,
  input  logic [47:0] cmd_symbol,
  input  logic [63:0] cmd_price,
  input  logic [63:0] cmd_exec_id,
  output logic [63:0] out_bytes,
  output logic [7:0]  out_byte_enables,
  output logic        out_data_valid,
  input  logic        out_ready,
  output logic [31:0] seq_num,
  output logic        err_unsupported
);

  state_e      state_q, state_d;
  logic [31:0] seq_q;
  logic        ready_q, err_q;
  cmd_t        cmd;
  logic        accept, supported, need_time, load, ser_done;
  unit_t       unit_d;

  assign cmd = {cmd_type, cmd_seconds, cmd_nanoseconds, cmd_order_id, cmd_side,
                cmd_quantity, cmd_symbol, cmd_price, cmd_exec_id};
  assign accept    = cmd_valid & ready_q;
  assign supported = (msg_len(cmd_type) != 6'd0);

`ifdef BATS_ENC_AUTO_TIME_EN
  logic [31:0] last_sec_q;
  logic        last_sec_vld_q;
  cmd_t        pend_q;
  cmd_t        time_cmd;

  assign need_time = supported && (cmd_type != MSG_TIME) &&
                     (!last_sec_vld_q || (cmd_seconds != last_sec_q));

  always_comb begin
    time_cmd     = cmd;
    time_cmd.typ = MSG_TIME;
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      last_sec_q     <= '0;
      last_sec_vld_q <= 1'b0;
      pend_q         <= '0;
    end else if (state_q == ST_IDLE && accept && supported) begin
      pend_q <= cmd;
      if (cmd_type == MSG_TIME || need_time) begin
        last_sec_q     <= cmd_seconds;
        last_sec_vld_q <= 1'b1;
      end
    end
  end
`else
  assign need_time = 1'b0;
`endif

  always_ff @(posedge Clk40) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept && supported) state_d = need_time ? ST_TIME_SEND : ST_SEND;
      ST_TIME_SEND: if (ser_done) state_d = ST_SEND;
      ST_SEND:      if (ser_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    unit_d = build_unit(cmd, UNIT_ID, seq_q);
    case (state_q)
      ST_IDLE: begin
        if (accept && supported) begin
          load = 1'b1;
`ifdef BATS_ENC_AUTO_TIME_EN
          if (need_time) unit_d = build_unit(time_cmd, UNIT_ID, seq_q);
`endif
        end
      end
`ifdef BATS_ENC_AUTO_TIME_EN
      // queued command follows its Time unit back-to-back with the next sequence number
      ST_TIME_SEND: begin
        if (ser_done) begin
          load   = 1'b1;
          unit_d = build_unit(pend_q, UNIT_ID, seq_q + 32'd1);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      seq_q   <= SEQ_INIT;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_IDLE);
      err_q   <= (state_q == ST_IDLE) && accept && !supported;
      if (ser_done) seq_q <= seq_q + 32'd1;
    end
  end

  bats_word_serializer u_ser (
    .clk_i         (Clk40),
    .reset_i       (reset),
    .load_i        (load),
    .unit_i        (unit_d),
    .out_ready_i   (out_ready),
    .out_bytes_o   (out_bytes),
    .out_be_o      (out_byte_enables),
    .out_valid_o   (out_data_valid),
    .last_accept_o (ser_done)
  );

  assign cmd_ready       = ready_q;
  assign seq_num         = seq_q;
  assign err_unsupported = err_q;

endmodule

// File: tb/tb_bats_pitch_encoder.sv
// Directed bench for bats_pitch_encoder: two instances (SEQ_INIT=2 and SEQ_INIT=0xFFFFFFFF).
module tb_bats_pitch_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  c_type, c_side;
  logic [31:0] c_sec, c_ns, c_qty;
  logic [63:0] c_oid, c_price, c_exec;
  logic [47:0] c_sym;

  logic        a_cv, a_ordy, a_rdy, a_dv, a_err;
  logic [63:0] a_bytes;
  logic [7:0]  a_be;
  logic [31:0] a_seq;
  logic        b_cv, b_ordy, b_rdy, b_dv, b_err;
  logic [63:0] b_bytes;
  logic [7:0]  b_be;
  logic [31:0] b_seq;

  bats_pitch_encoder #(.UNIT_ID(8'd1), .SEQ_INIT(32'd2)) dut_a (
    .Clk40(clk), .reset(reset), .cmd_valid(a_cv), .cmd_ready(a_rdy),
    .cmd_type(c_type), .cmd_seconds(c_sec), .cmd_nanoseconds(c_ns),
    .cmd_order_id(c_oid), .cmd_side(c_side), .cmd_quantity(c_qty),
    .cmd_symbol(c_sym), .cmd_price(c_price), .cmd_exec_id(c_exec),
    .out_bytes(a_bytes), .out_byte_enables(a_be), .out_data_valid(a_dv),
    .out_ready(a_ordy), .seq_num(a_seq), .err_unsupported(a_err));

  bats_pitch_encoder #(.UNIT_ID(8'd1), .SEQ_INIT(32'hFFFFFFFF)) dut_b (
    .Clk40(clk), .reset(reset), .cmd_valid(b_cv), .cmd_ready(b_rdy),
    .cmd_type(c_type), .cmd_seconds(c_sec), .cmd_nanoseconds(c_ns),
    .cmd_order_id(c_oid), .cmd_side(c_side), .cmd_quantity(c_qty),
    .cmd_symbol(c_sym), .cmd_price(c_price), .cmd_exec_id(c_exec),
    .out_bytes(b_bytes), .out_byte_enables(b_be), .out_data_valid(b_dv),
    .out_ready(b_ordy), .seq_num(b_seq), .err_unsupported(b_err));

  int   total = 0;
  int   bad = 0;
  logic sel;
  logic        m_rdy, m_dv;
  logic [63:0] m_bytes;
  logic [7:0]  m_be;

  always_comb begin
    m_rdy   = sel ? b_rdy : a_rdy;
    m_dv    = sel ? b_dv : a_dv;
    m_bytes = sel ? b_bytes : a_bytes;
    m_be    = sel ? b_be : a_be;
  end

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] sec, ns, qty;
    logic [63:0] oid, price, exec;
    logic [7:0]  side;
    logic [47:0] sym;
    int          nw;
    logic [63:0] w [6];
    logic [7:0]  be;
    logic [31:0] seq_after;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] t);
    int n = 0;
    c_type = t;
    while (!m_rdy && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", m_rdy, 1);
    if (sel) b_cv = 1'b1; else a_cv = 1'b1;
    tick();
    a_cv = 1'b0;
    b_cv = 1'b0;
  endtask

  task automatic recv(input string name, input logic [63:0] w, input logic [7:0] be);
    int n = 0;
    while (!m_dv && n < 50) begin
      tick();
      n++;
    end
    check({name, "_valid"}, m_dv, 1);
    check({name, "_data"}, m_bytes, w);
    check({name, "_be"}, m_be, be);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Time, seq 2
    vt[0] = '{typ:8'h20, sec:32'h0006D219, ns:0, qty:0, oid:0, price:0, exec:0, side:0, sym:0,
              nw:2, w:'{64'h0E00010102000000, 64'h062019D206000000, 0, 0, 0, 0},
              be:8'hFC, seq_after:32'd3};
    // Delete, seq 3
    vt[1] = '{typ:8'h29, sec:32'h0006D219, ns:32'h11223344, qty:0, oid:64'h0102030405060708,
              price:0, exec:0, side:0, sym:0, nw:3,
              w:'{64'h1600010103000000, 64'h0E29443322110807, 64'h0605040302010000, 0, 0, 0},
              be:8'hFC, seq_after:32'd4};
    // Executed, seq 4
    vt[2] = '{typ:8'h23, sec:32'h0006D219, ns:32'h1, qty:32'h1F4, oid:64'hAB, price:0,
              exec:64'h1122334455667788, side:0, sym:0, nw:5,
              w:'{64'h2200010104000000, 64'h1A230100_0000AB00, 64'h00000000_0000F401,
                  64'h00008877_66554433, 64'h22110000_00000000, 0},
              be:8'hC0, seq_after:32'd5};
    // AddLong, seq 5
    vt[3] = '{typ:8'h21, sec:32'h0006D219, ns:32'h0, qty:32'h200, oid:64'h10,
              price:64'h0102030405060708, exec:0, side:8'h53, sym:48'h4D5346542020, nw:6,
              w:'{64'h2A00010105000000, 64'h22210000_00001000, 64'h00000000_00005300,
                  64'h0200004D_53465420, 64'h20080706_05040302, 64'h01000000_00000000},
              be:8'hC0, seq_after:32'd6};

    reset = 1'b1; sel = 1'b0;
    a_cv = 1'b0; b_cv = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
    c_type = 0; c_sec = 0; c_ns = 0; c_qty = 0; c_oid = 0; c_price = 0; c_exec = 0;
    c_side = 0; c_sym = 0;
    repeat (3) tick();
    check("rst_cmd_ready", a_rdy, 0);
    check("rst_valid", a_dv, 0);
    check("rst_bytes", a_bytes, 0);
    check("rst_be", a_be, 0);
    check("rst_err", a_err, 0);
    check("rst_seq_a", a_seq, 32'd2);
    check("rst_seq_b", b_seq, 32'hFFFFFFFF);
    reset = 1'b0;
    tick();
    check("ready_after_release", a_rdy, 1);

    for (int i = 0; i < 4; i++) begin
      c_sec = vt[i].sec; c_ns = vt[i].ns; c_qty = vt[i].qty; c_oid = vt[i].oid;
      c_price = vt[i].price; c_exec = vt[i].exec; c_side = vt[i].side; c_sym = vt[i].sym;
      send(vt[i].typ);
      check($sformatf("v%0d_ready_low", i), a_rdy, 0);
      for (int k = 0; k < vt[i].nw; k++)
        recv($sformatf("v%0d_w%0d", i, k), vt[i].w[k], (k == vt[i].nw - 1) ? vt[i].be : 8'hFF);
      check($sformatf("v%0d_gap", i), a_dv, 0);
      check($sformatf("v%0d_seq", i), a_seq, vt[i].seq_after);
    end

    // backpressure on the last word of a Time unit
    c_sec = 32'h0006D219;
    send(8'h20);
    recv("stall_w0", 64'h0E00010106000000, 8'hFF);
    a_ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_hold_valid", a_dv, 1);
      check("stall_hold_data", a_bytes, 64'h062019D206000000);
      check("stall_hold_be", a_be, 8'hFC);
      tick();
    end
    a_ordy = 1'b1;
    check("stall_release_data", a_bytes, 64'h062019D206000000);
    tick();
    check("stall_no_dup", a_dv, 0);
    check("stall_seq", a_seq, 32'd7);

    // unsupported type
    send(8'h99);
    check("unsup_err", a_err, 1);
    check("unsup_valid", a_dv, 0);
    tick();
    check("unsup_err_pulse", a_err, 0);
    check("unsup_valid2", a_dv, 0);
    check("unsup_seq", a_seq, 32'd7);
    check("unsup_ready", a_rdy, 1);

    // two Deletes with new seconds
    c_sec = 32'd100; c_ns = 32'h11223344; c_oid = 64'h0102030405060708;
    send(8'h29);
`ifdef BATS_ENC_AUTO_TIME_EN
    recv("t6_time_w0", 64'h0E00010107000000, 8'hFF);
    recv("t6_time_w1", 64'h0620640000000000, 8'hFC);
    recv("t6_d1_w0", 64'h1600010108000000, 8'hFF);
`else
    recv("t6_d1_w0", 64'h1600010107000000, 8'hFF);
`endif
    recv("t6_d1_w1", 64'h0E29443322110807, 8'hFF);
    recv("t6_d1_w2", 64'h0605040302010000, 8'hFC);
    send(8'h29);
`ifdef BATS_ENC_AUTO_TIME_EN
    recv("t6_d2_w0", 64'h1600010109000000, 8'hFF);
`else
    recv("t6_d2_w0", 64'h1600010108000000, 8'hFF);
`endif
    recv("t6_d2_w1", 64'h0E29443322110807, 8'hFF);
    recv("t6_d2_w2", 64'h0605040302010000, 8'hFC);
`ifdef BATS_ENC_AUTO_TIME_EN
    check("t6_seq", a_seq, 32'd10);
`else
    check("t6_seq", a_seq, 32'd9);
`endif

    // AddLong on the wrap-around instance
    sel = 1'b1;
    c_sec = 32'd100; c_ns = 32'h0A0B0C0D; c_oid = 64'h1; c_qty = 32'd100;
    c_sym = "AAPL  "; c_price = 64'd1500000; c_side = 8'h42; c_exec = 0;
    send(8'h21);
`ifdef BATS_ENC_AUTO_TIME_EN
    recv("t3_time_w0", 64'h0E000101FFFFFFFF, 8'hFF);
    recv("t3_time_w1", 64'h0620640000000000, 8'hFC);
    recv("t3_w0", 64'h2A00010100000000, 8'hFF);
`else
    recv("t3_w0", 64'h2A000101FFFFFFFF, 8'hFF);
`endif
    recv("t3_w1", 64'h22210D0C0B0A0100, 8'hFF);
    recv("t3_w2", 64'h0000000000004264, 8'hFF);
    recv("t3_w3", 64'h000000414150_4C20, 8'hFF);
    recv("t3_w4", 64'h2060E31600000000, 8'hFF);
    recv("t3_w5", 64'h0000000000000000, 8'hC0);
`ifdef BATS_ENC_AUTO_TIME_EN
    check("t3_seq_wrap", b_seq, 32'd1);
`else
    check("t3_seq_wrap", b_seq, 32'd0);
`endif

    // reset mid-unit
    sel = 1'b0;
    c_sec = 32'd100; c_ns = 32'h11223344; c_oid = 64'h0102030405060708;
    send(8'h29);
`ifdef BATS_ENC_AUTO_TIME_EN
    recv("t5_w0", 64'h160001010A000000, 8'hFF);
`else
    recv("t5_w0", 64'h1600010109000000, 8'hFF);
`endif
    reset = 1'b1;
    tick();
    check("t5_valid_drop", a_dv, 0);
    check("t5_seq_reload", a_seq, 32'd2);
    check("t5_ready_in_reset", a_rdy, 0);
    reset = 1'b0;
    check("t5_ready_at_release", a_rdy, 0);
    tick();
    check("t5_ready_rise", a_rdy, 1);
    check("t5_valid_idle", a_dv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
